// File: rtl/result_drain.sv
// result_drain: drains K_CHANNELS x line_len accumulator words from the result
// line buffers, saturates each to OUT_WIDTH and streams them on a valid/ready
// master. Optional fused ReLU: define RESULT_DRAIN_RELU_EN.
module result_drain #(
  parameter int K_CHANNELS = 6,
  parameter int MAX_LINE_W = 32,
  parameter int ACC_WIDTH  = 32,
  parameter int OUT_WIDTH  = 16
) (
  input  logic                              clk_i,
  input  logic                              rst_async_n_i,
  input  logic                              start_i,
  input  logic [$clog2(MAX_LINE_W+1)-1:0]   line_len_i,
  output logic                              rd_en_o,
  output logic [$clog2(K_CHANNELS)-1:0]     rd_ch_o,
  output logic [$clog2(MAX_LINE_W)-1:0]     rd_addr_o,
  input  logic [ACC_WIDTH-1:0]              rd_data_i,
  output logic                              m_valid_o,
  input  logic                              m_ready_i,
  output logic [OUT_WIDTH-1:0]              m_data_o,
  output logic [$clog2(K_CHANNELS)-1:0]     m_ch_o,
  output logic                              m_last_o,
  output logic                              m_frame_last_o,
  output logic                              busy_o,
  output logic                              done_o
);

  localparam int LW = $clog2(MAX_LINE_W+1);
  localparam int CW = $clog2(K_CHANNELS);
  localparam int AW = $clog2(MAX_LINE_W);

  localparam logic signed [ACC_WIDTH-1:0] SAT_MAX =
    $signed(ACC_WIDTH'((64'd1 << (OUT_WIDTH-1)) - 64'd1));
  localparam logic signed [ACC_WIDTH-1:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_FLUSH, S_DONE} state_t;

  state_t r_state, w_nextState;

  logic [LW-1:0] r_len;
  logic [CW-1:0] r_ch;
  logic [AW-1:0] r_addr;

  logic          r_infl;
  logic [CW-1:0] r_inflCh;
  logic          r_inflLast;
  logic          r_inflFrame;

  logic [OUT_WIDTH-1:0] r_fData  [2];
  logic [CW-1:0]        r_fCh    [2];
  logic                 r_fLast  [2];
  logic                 r_fFrame [2];
  logic                 r_wrPtr;
  logic                 r_rdPtr;
  logic [1:0]           r_count;

  logic [LW-1:0]        w_lenClamped;
  logic                 w_lastAddr;
  logic                 w_lastCh;
  logic                 w_rdEn;
  logic                 w_valid;
  logic                 w_push;
  logic                 w_pop;
  logic [OUT_WIDTH-1:0] w_satData;

  assign w_lenClamped = (line_len_i > LW'(MAX_LINE_W)) ? LW'(MAX_LINE_W) : line_len_i;
  assign w_lastAddr   = (LW'(r_addr) == (r_len - LW'(1)));
  assign w_lastCh     = (r_ch == CW'(K_CHANNELS-1));
  // A read is only issued when the word it returns is certain to find a FIFO slot.
  assign w_rdEn       = (r_state == S_READ) && ((r_count + {1'b0, r_infl}) < 2'd2);
  assign w_valid      = (r_count != 2'd0);
  assign w_push       = r_infl;
  assign w_pop        = w_valid && m_ready_i;

  // State register; an asynchronous reset aborts any drain in progress.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) r_state <= S_IDLE;
    else                r_state <= w_nextState;
  end

  // Next-state logic: READ ends with the final issue, FLUSH ends when the frame-last word leaves.
  always_comb begin
    w_nextState = r_state;
    case (r_state)
      S_IDLE:  if (start_i) w_nextState = (w_lenClamped == '0) ? S_DONE : S_READ;
      S_READ:  if (w_rdEn && w_lastAddr && w_lastCh) w_nextState = S_FLUSH;
      S_FLUSH: if ((w_pop && r_fFrame[r_rdPtr]) || (!w_valid && !r_infl)) w_nextState = S_DONE;
      S_DONE:  w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Channel-major address walk over the latched, clamped line length.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_len  <= '0;
      r_ch   <= '0;
      r_addr <= '0;
    end else if (r_state == S_IDLE && start_i) begin
      r_len  <= w_lenClamped;
      r_ch   <= '0;
      r_addr <= '0;
    end else if (w_rdEn) begin
      if (w_lastAddr) begin
        r_addr <= '0;
        r_ch   <= w_lastCh ? '0 : r_ch + CW'(1);
      end else begin
        r_addr <= r_addr + AW'(1);
      end
    end
  end

  // Tag the outstanding read so its sideband travels with the data one cycle later.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      r_infl      <= 1'b0;
      r_inflCh    <= '0;
      r_inflLast  <= 1'b0;
      r_inflFrame <= 1'b0;
    end else begin
      r_infl      <= w_rdEn;
      r_inflCh    <= r_ch;
      r_inflLast  <= w_lastAddr;
      r_inflFrame <= w_lastAddr && w_lastCh;
    end
  end

  // Signed saturation to OUT_WIDTH, optionally followed by the fused ReLU.
  always_comb begin
    w_satData = rd_data_i[OUT_WIDTH-1:0];
    if ($signed(rd_data_i) > SAT_MAX)      w_satData = SAT_MAX[OUT_WIDTH-1:0];
    else if ($signed(rd_data_i) < SAT_MIN) w_satData = SAT_MIN[OUT_WIDTH-1:0];
`ifdef RESULT_DRAIN_RELU_EN
    if (w_satData[OUT_WIDTH-1]) w_satData = '0;
`endif
  end

  // Two-entry output FIFO; returning data is written in the cycle it arrives.
  always_ff @(posedge clk_i or negedge rst_async_n_i) begin
    if (!rst_async_n_i) begin
      for (int i = 0; i < 2; i++) begin
        r_fData[i]  <= '0;
        r_fCh[i]    <= '0;
        r_fLast[i]  <= 1'b0;
        r_fFrame[i] <= 1'b0;
      end
      r_wrPtr <= 1'b0;
      r_rdPtr <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_fData[r_wrPtr]  <= w_satData;
        r_fCh[r_wrPtr]    <= r_inflCh;
        r_fLast[r_wrPtr]  <= r_inflLast;
        r_fFrame[r_wrPtr] <= r_inflFrame;
        r_wrPtr           <= ~r_wrPtr;
      end
      if (w_pop) r_rdPtr <= ~r_rdPtr;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 2'd1;
        2'b01:   r_count <= r_count - 2'd1;
        default: r_count <= r_count;
      endcase
    end
  end

  assign rd_en_o        = w_rdEn;
  assign rd_ch_o        = w_rdEn ? r_ch : '0;
  assign rd_addr_o      = w_rdEn ? r_addr : '0;
  assign m_valid_o      = w_valid;
  assign m_data_o       = w_valid ? r_fData[r_rdPtr] : '0;
  assign m_ch_o         = w_valid ? r_fCh[r_rdPtr] : '0;
  assign m_last_o       = w_valid && r_fLast[r_rdPtr];
  assign m_frame_last_o = w_valid && r_fFrame[r_rdPtr];
  assign busy_o         = (r_state == S_READ) || (r_state == S_FLUSH);
  assign done_o         = (r_state == S_DONE);

endmodule

// File: tb/tb_result_drain.sv
// tb_result_drain: scoreboard bench for result_drain (default parameters).
module tb_result_drain;

  localparam int K    = 6;
  localparam int MAXW = 32;

  logic        clk_i = 1'b0;
  logic        rst_async_n_i;
  logic        start_i;
  logic [5:0]  line_len_i;
  logic        rd_en_o;
  logic [2:0]  rd_ch_o;
  logic [4:0]  rd_addr_o;
  logic [31:0] rd_data_i = 32'h0;
  logic        m_valid_o;
  logic        m_ready_i;
  logic [15:0] m_data_o;
  logic [2:0]  m_ch_o;
  logic        m_last_o;
  logic        m_frame_last_o;
  logic        busy_o;
  logic        done_o;

  typedef struct packed {
    logic [15:0] data;
    logic [2:0]  ch;
    logic        last;
    logic        frame;
  } exp_t;

  exp_t        expQ[$];
  logic [31:0] mem [K][MAXW];
  int          checks = 0;
  int          errors = 0;
  int          hsCount = 0;
  int          zeroStarts = 0;
  int          zeroSeen = 0;
  int          tbIssued = 0;
  int          tbPopped = 0;
  bit          doneExp = 0;
  bit          stallHeld = 0;
  logic [20:0] heldWord = '0;
  int          readyMode = 0;

  result_drain dut (
    .clk_i          (clk_i),
    .rst_async_n_i  (rst_async_n_i),
    .start_i        (start_i),
    .line_len_i     (line_len_i),
    .rd_en_o        (rd_en_o),
    .rd_ch_o        (rd_ch_o),
    .rd_addr_o      (rd_addr_o),
    .rd_data_i      (rd_data_i),
    .m_valid_o      (m_valid_o),
    .m_ready_i      (m_ready_i),
    .m_data_o       (m_data_o),
    .m_ch_o         (m_ch_o),
    .m_last_o       (m_last_o),
    .m_frame_last_o (m_frame_last_o),
    .busy_o         (busy_o),
    .done_o         (done_o)
  );

  always #5 clk_i = ~clk_i;

  // Compare one observed value against its expectation and log any failure.
  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference saturation: clamp to signed 16-bit range, optional ReLU.
  function automatic logic [15:0] satModel(input logic [31:0] v);
    int s;
    logic [15:0] r;
    s = $signed(v);
    if (s > 32767)       r = 16'h7FFF;
    else if (s < -32768) r = 16'h8000;
    else                 r = v[15:0];
`ifdef RESULT_DRAIN_RELU_EN
    if (r[15]) r = 16'h0000;
`endif
    return r;
  endfunction

  task automatic loadPattern();
    for (int k = 0; k < K; k++)
      for (int a = 0; a < MAXW; a++)
        mem[k][a] = 32'(k * 100 + a);
  endtask

  // Pulse start with a line length and push the words the drain should produce.
  task automatic applyStimulus(input int len);
    int L;
    exp_t e;
    L = (len > MAXW) ? MAXW : len;
    for (int k = 0; k < K; k++)
      for (int a = 0; a < L; a++) begin
        e.data  = satModel(mem[k][a]);
        e.ch    = 3'(k);
        e.last  = (a == L - 1);
        e.frame = (a == L - 1) && (k == K - 1);
        expQ.push_back(e);
      end
    line_len_i = 6'(len);
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    if (L == 0) zeroStarts++;
  endtask

  // Wait for done_o with a cycle budget, then step into the following IDLE cycle.
  task automatic waitDrain(input int budget, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (done_o === 1'b1) seen = 1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
    @(posedge clk_i);
    #1;
  endtask

  task automatic waitWords(input int target, input int budget, input string tag);
    bit seen;
    seen = 0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk_i);
      if (hsCount >= target) seen = 1;
    end
    checkOutput(tag, 64'(seen), 64'd1);
  endtask

  // Read-port model: data returns exactly one cycle after the strobe, garbage otherwise.
  initial forever begin
    @(posedge clk_i);
    rd_data_i <= rd_en_o ? mem[rd_ch_o][rd_addr_o] : 32'hDEAD_BEEF;
  end

  // Downstream ready: always high, or the repeating 1,0,0 pattern.
  initial begin
    int phase;
    phase = 0;
    m_ready_i = 1'b1;
    forever begin
      @(posedge clk_i);
      #1;
      m_ready_i = (readyMode == 0) ? 1'b1 : (phase == 0);
      phase = (phase + 1) % 3;
    end
  end

  // Monitor: scoreboard pops, done timing, stall stability and read-issue limit.
  always @(negedge clk_i) begin
    if (!rst_async_n_i) begin
      tbIssued  = 0;
      tbPopped  = 0;
      stallHeld = 0;
      doneExp   = 0;
    end else begin
      if (doneExp) begin
        checkOutput("done_after_frame_last", 64'(done_o), 64'd1);
        doneExp = 0;
      end else if (zeroStarts != zeroSeen) begin
        checkOutput("done_zero_len", 64'(done_o), 64'd1);
        zeroSeen++;
      end else if (done_o !== 1'b0) begin
        checkOutput("done_unexpected", 64'(done_o), 64'd0);
      end
      if (stallHeld) begin
        checkOutput("stall_valid", 64'(m_valid_o), 64'd1);
        checkOutput("stall_stable", 64'({m_data_o, m_ch_o, m_last_o, m_frame_last_o}), 64'(heldWord));
      end
      if (rd_en_o === 1'b1) begin
        checkOutput("rd_slot_limit", 64'((tbIssued - tbPopped) < 2), 64'd1);
        tbIssued++;
      end
      if (m_valid_o === 1'b1 && m_ready_i === 1'b1) begin
        if (expQ.size() == 0) begin
          checkOutput("queue_underflow", 64'(expQ.size()), 64'd1);
        end else begin
          exp_t e;
          e = expQ.pop_front();
          checkOutput("word", 64'({m_data_o, m_ch_o, m_last_o, m_frame_last_o}), 64'(e));
          if (e.frame) doneExp = 1;
        end
        tbPopped++;
        hsCount++;
      end
      stallHeld = (m_valid_o === 1'b1) && (m_ready_i === 1'b0);
      heldWord  = {m_data_o, m_ch_o, m_last_o, m_frame_last_o};
    end
  end

  initial begin
    int base;
    rst_async_n_i = 1'b0;
    start_i       = 1'b0;
    line_len_i    = '0;
    loadPattern();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    checkOutput("reset_outputs",
      64'({rd_en_o, rd_ch_o, rd_addr_o, m_valid_o, m_data_o, m_ch_o, m_last_o, m_frame_last_o, busy_o, done_o}), 64'd0);
    @(posedge clk_i);
    #1;
    rst_async_n_i = 1'b1;
    @(posedge clk_i);
    #1;

    $display("[TB] basic drain, len=4");
    base = hsCount;
    applyStimulus(4);
    @(negedge clk_i);
    checkOutput("busy_after_start", 64'(busy_o), 64'd1);
    checkOutput("first_rd_en", 64'({rd_en_o, rd_ch_o, rd_addr_o}), 64'({1'b1, 3'd0, 5'd0}));
    checkOutput("valid_cycle1", 64'(m_valid_o), 64'd0);
    @(negedge clk_i);
    checkOutput("valid_cycle2", 64'(m_valid_o), 64'd0);
    @(negedge clk_i);
    checkOutput("valid_cycle3", 64'(m_valid_o), 64'd1);
    waitDrain(200, "drain1_timeout");
    checkOutput("drain1_count", 64'(hsCount - base), 64'd24);
    checkOutput("drain1_queue", 64'(expQ.size()), 64'd0);
    checkOutput("idle_not_busy", 64'(busy_o), 64'd0);

    $display("[TB] backpressure drain, ready 1,0,0");
    readyMode = 1;
    base = hsCount;
    applyStimulus(4);
    waitDrain(400, "drain2_timeout");
    readyMode = 0;
    checkOutput("drain2_count", 64'(hsCount - base), 64'd24);
    checkOutput("drain2_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] saturation");
    mem[0][0] = 32'h0001_0000;
    mem[0][1] = 32'hFFFF_0000;
    mem[0][2] = 32'h0000_1234;
    mem[0][3] = 32'hFFFF_FF00;
    mem[1][0] = 32'h7FFF_FFFF;
    mem[1][1] = 32'h8000_0000;
    mem[1][2] = 32'h0000_7FFF;
    mem[1][3] = 32'hFFFF_8000;
    base = hsCount;
    applyStimulus(4);
    waitDrain(200, "drain3_timeout");
    checkOutput("drain3_count", 64'(hsCount - base), 64'd24);
    loadPattern();

    $display("[TB] zero length and clamped length");
    base = hsCount;
    applyStimulus(0);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk_i);
      checkOutput("zero_len_quiet", 64'({rd_en_o, m_valid_o, busy_o}), 64'd0);
    end
    checkOutput("zero_len_count", 64'(hsCount - base), 64'd0);
    @(posedge clk_i);
    #1;
    base = hsCount;
    applyStimulus(40);
    waitDrain(2000, "drain4_timeout");
    checkOutput("clamp_count", 64'(hsCount - base), 64'd192);
    checkOutput("clamp_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] restart ignored while busy");
    base = hsCount;
    applyStimulus(4);
    waitWords(base + 5, 200, "restart_wait_timeout");
    @(posedge clk_i);
    #1;
    line_len_i = 6'd2;
    start_i    = 1'b1;
    @(posedge clk_i);
    #1;
    start_i = 1'b0;
    waitDrain(200, "drain5_timeout");
    checkOutput("restart_count", 64'(hsCount - base), 64'd24);
    checkOutput("restart_queue", 64'(expQ.size()), 64'd0);

    $display("[TB] reset mid-drain");
    base = hsCount;
    applyStimulus(4);
    waitWords(base + 10, 200, "reset_wait_timeout");
    #2;
    rst_async_n_i = 1'b0;
    #1;
    checkOutput("reset_mid_outputs",
      64'({rd_en_o, rd_ch_o, rd_addr_o, m_valid_o, m_data_o, m_ch_o, m_last_o, m_frame_last_o, busy_o, done_o}), 64'd0);
    expQ.delete();
    repeat (3) @(posedge clk_i);
    #1;
    rst_async_n_i = 1'b1;
    repeat (3) @(negedge clk_i);
    checkOutput("no_done_after_reset", 64'({done_o, busy_o}), 64'd0);
    @(posedge clk_i);
    #1;
    base = hsCount;
    applyStimulus(4);
    waitDrain(200, "drain6_timeout");
    checkOutput("post_reset_count", 64'(hsCount - base), 64'd24);
    checkOutput("post_reset_queue", 64'(expQ.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
